// File: rtl/pmod_bridge_pkg.sv
// Shared defaults and width helpers for the Pmod stream bridge.
package pmod_bridge_pkg;
    localparam int DATA_W_DEF   = 8;
    localparam int RX_DEPTH_DEF = 8;
    localparam int TX_DEPTH_DEF = 4;
    localparam int SKID_DEF     = 2;

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/pmod_fifo.sv
// Synchronous show-ahead FIFO; push at full is accepted only alongside a pop.
// Level carries one extra bit so full and empty are distinguishable.
module pmod_fifo
    import pmod_bridge_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic                    clk_io_bus,
    input  logic                    rst_async,
    input  logic                    push_i,
    input  logic [DATA_W-1:0]       push_dat_i,
    input  logic                    pop_i,
    output logic [DATA_W-1:0]       head_dat_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [lvl_w(DEPTH)-1:0] level_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = lvl_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              wr_en, rd_en;

    assign full_o     = (level_q == LVL_W'(DEPTH));
    assign empty_o    = (level_q == '0);
    assign head_dat_o = mem_q[rd_ptr_q];
    assign level_o    = level_q;

    always_comb begin
        rd_en    = pop_i && !empty_o;
        wr_en    = push_i && (!full_o || rd_en);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = push_dat_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        level_d = level_q + LVL_W'(wr_en) - LVL_W'(rd_en);
    end

    always_ff @(posedge clk_io_bus or posedge rst_async) begin
        if (rst_async) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end
endmodule

// File: rtl/pmod_stream_bridge.sv
// Pmod <-> core bridge: IOB-captured host words into an RX FIFO with skid-margin ready,
// core results through a TX FIFO launched from registered pins when the host is ready.
module pmod_stream_bridge
    import pmod_bridge_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int RX_DEPTH = RX_DEPTH_DEF,
    parameter int TX_DEPTH = TX_DEPTH_DEF,
    parameter int SKID     = SKID_DEF
) (
    input  logic                       clk_io_bus,
    input  logic                       rst_async,
    input  logic [DATA_W-1:0]          pmod_data_i,
    input  logic                       pmod_valid_i,
    output logic                       pmod_ready_o,
    output logic [DATA_W-1:0]          core_data_o,
    output logic                       core_valid_o,
    input  logic                       core_ready_i,
    input  logic [DATA_W-1:0]          core_hash_i,
    input  logic                       core_hash_valid_i,
    output logic                       core_hash_ready_o,
    output logic [DATA_W-1:0]          pmod_hash_o,
    output logic                       pmod_hash_valid_o,
    input  logic                       pmod_hash_ready_i,
    output logic [lvl_w(RX_DEPTH)-1:0] rx_level_o,
    output logic                       overflow_o
);
    localparam int RX_LVL_W = lvl_w(RX_DEPTH);
    localparam int TX_LVL_W = lvl_w(TX_DEPTH);

    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                hrdy_q, hrdy_d;
    logic                ready_q, ready_d;
    logic                ovf_q, ovf_d;
    logic [DATA_W-1:0]   hash_q, hash_d;
    logic                hash_vld_q, hash_vld_d;

    logic                rx_push, rx_pop, rx_full, rx_empty;
    logic [DATA_W-1:0]   rx_head;
    logic [RX_LVL_W-1:0] rx_level, rx_level_next;
    logic                tx_push, tx_pop, tx_full, tx_empty;
    logic [DATA_W-1:0]   tx_head;
    logic [TX_LVL_W-1:0] tx_level_unused;

    always_comb begin
        data_d  = pmod_data_i;
        valid_d = pmod_valid_i;
        hrdy_d  = pmod_hash_ready_i;

        rx_pop  = !rx_empty && core_ready_i;
        rx_push = valid_q && (!rx_full || rx_pop);
        ovf_d   = ovf_q || (valid_q && rx_full && !rx_pop);
        rx_level_next = rx_level + RX_LVL_W'(rx_push) - RX_LVL_W'(rx_pop);
        // Ready looks at the post-edge level so the skid margin covers words already in flight.
        ready_d = (RX_DEPTH - int'(rx_level_next)) > SKID;

        tx_push    = core_hash_valid_i && !tx_full;
        tx_pop     = hrdy_q && !tx_empty;
        hash_vld_d = tx_pop;
        hash_d     = tx_pop ? tx_head : hash_q;
    end

    always_ff @(posedge clk_io_bus or posedge rst_async) begin
        if (rst_async) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            hrdy_q     <= 1'b0;
            ready_q    <= 1'b0;
            ovf_q      <= 1'b0;
            hash_q     <= '0;
            hash_vld_q <= 1'b0;
        end else begin
            data_q     <= data_d;
            valid_q    <= valid_d;
            hrdy_q     <= hrdy_d;
            ready_q    <= ready_d;
            ovf_q      <= ovf_d;
            hash_q     <= hash_d;
            hash_vld_q <= hash_vld_d;
        end
    end

    pmod_fifo #(.DATA_W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_io_bus (clk_io_bus),
        .rst_async  (rst_async),
        .push_i     (rx_push),
        .push_dat_i (data_q),
        .pop_i      (rx_pop),
        .head_dat_o (rx_head),
        .full_o     (rx_full),
        .empty_o    (rx_empty),
        .level_o    (rx_level)
    );

    pmod_fifo #(.DATA_W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_io_bus (clk_io_bus),
        .rst_async  (rst_async),
        .push_i     (tx_push),
        .push_dat_i (core_hash_i),
        .pop_i      (tx_pop),
        .head_dat_o (tx_head),
        .full_o     (tx_full),
        .empty_o    (tx_empty),
        .level_o    (tx_level_unused)
    );

    assign pmod_ready_o      = ready_q;
    assign core_data_o       = rx_head;
    assign core_valid_o      = !rx_empty;
    assign rx_level_o        = rx_level;
    assign overflow_o        = ovf_q;
    assign core_hash_ready_o = !tx_full;
    assign pmod_hash_o       = hash_q;
    assign pmod_hash_valid_o = hash_vld_q;
endmodule

// File: tb/tb_pmod_stream_bridge.sv
// Bench for pmod_stream_bridge: directed scenarios plus random traffic against a queue model.
module tb_pmod_stream_bridge;
    localparam int DW = 8, RXD = 8, TXD = 4, SKID = 2, LW = 4;

    logic          clk_io_bus = 1'b0;
    logic          rst_async  = 1'b1;
    logic [DW-1:0] pmod_data_i, core_data_o, core_hash_i, pmod_hash_o;
    logic          pmod_valid_i, pmod_ready_o, core_valid_o, core_ready_i;
    logic          core_hash_valid_i, core_hash_ready_o, pmod_hash_valid_o, pmod_hash_ready_i;
    logic [LW-1:0] rx_level_o;
    logic          overflow_o;

    int checks, failures;

    // Behavioural model: pin registers plus plain queues for the two FIFOs.
    bit            m_vq, m_hrq, m_ready, m_ovf, m_hvld;
    logic [DW-1:0] m_dq, m_hash;
    logic [DW-1:0] rxq[$];
    logic [DW-1:0] txq[$];

    pmod_stream_bridge #(.DATA_W(DW), .RX_DEPTH(RXD), .TX_DEPTH(TXD), .SKID(SKID)) dut (
        .clk_io_bus        (clk_io_bus),
        .rst_async         (rst_async),
        .pmod_data_i       (pmod_data_i),
        .pmod_valid_i      (pmod_valid_i),
        .pmod_ready_o      (pmod_ready_o),
        .core_data_o       (core_data_o),
        .core_valid_o      (core_valid_o),
        .core_ready_i      (core_ready_i),
        .core_hash_i       (core_hash_i),
        .core_hash_valid_i (core_hash_valid_i),
        .core_hash_ready_o (core_hash_ready_o),
        .pmod_hash_o       (pmod_hash_o),
        .pmod_hash_valid_o (pmod_hash_valid_o),
        .pmod_hash_ready_i (pmod_hash_ready_i),
        .rx_level_o        (rx_level_o),
        .overflow_o        (overflow_o)
    );

    always #5 clk_io_bus = ~clk_io_bus;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // Advance one edge; the model consumes the inputs the DUT sees at that edge.
    task automatic tick();
        bit rx_pop, rx_push, tx_push, tx_pop;
        rx_pop  = (rxq.size() != 0) && core_ready_i;
        rx_push = m_vq && ((rxq.size() < RXD) || rx_pop);
        if (m_vq && !rx_push) m_ovf = 1'b1;
        tx_push = core_hash_valid_i && (txq.size() < TXD);
        tx_pop  = m_hrq && (txq.size() != 0);
        if (rx_pop) void'(rxq.pop_front());
        if (rx_push) rxq.push_back(m_dq);
        m_ready = (RXD - rxq.size()) > SKID;
        if (tx_pop) m_hash = txq.pop_front();
        m_hvld = tx_pop;
        if (tx_push) txq.push_back(core_hash_i);
        m_vq  = pmod_valid_i;
        m_dq  = pmod_data_i;
        m_hrq = pmod_hash_ready_i;
        @(posedge clk_io_bus);
        #1;
    endtask

    task automatic apply_reset();
        rst_async = 1'b1;
        pmod_valid_i = 1'b0; pmod_data_i = '0; core_ready_i = 1'b0;
        core_hash_valid_i = 1'b0; core_hash_i = '0; pmod_hash_ready_i = 1'b0;
        rxq.delete(); txq.delete();
        m_vq = 0; m_hrq = 0; m_ready = 0; m_ovf = 0; m_hvld = 0; m_dq = '0; m_hash = '0;
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk_io_bus);
        #1;
        rst_async = 1'b0;
    endtask

    task automatic test_reset();
        logic [25:0] act;
        apply_reset();
        @(posedge clk_io_bus); #1;
        act = {pmod_ready_o, core_valid_o, pmod_hash_valid_o, pmod_hash_o, overflow_o,
               rx_level_o, core_data_o, core_hash_ready_o};
        checks++;
        if (act !== 26'h1) begin
            failures++;
            $display("FAIL reset_outputs: got %h want %h", act, 26'h1);
        end
        release_reset();
        tick();
        checks++;
        if ({pmod_ready_o, core_hash_ready_o, overflow_o, core_valid_o} !== 4'b1100) begin
            failures++;
            $display("FAIL reset_release: ready/hrdy/ovf/cvld got %b want 1100",
                     {pmod_ready_o, core_hash_ready_o, overflow_o, core_valid_o});
        end
        for (int i = 0; i < 5; i++) begin
            pmod_valid_i = 1'b1; pmod_data_i = DW'($urandom);
            tick();
        end
        pmod_valid_i = 1'b0;
        tick();
        checks++;
        if (rx_level_o !== 4'd5) begin
            failures++;
            $display("FAIL reset_prefill_level: got %0d want 5", rx_level_o);
        end
        #2;
        apply_reset();
        act = {pmod_ready_o, core_valid_o, pmod_hash_valid_o, pmod_hash_o, overflow_o,
               rx_level_o, core_data_o, core_hash_ready_o};
        checks++;
        if (act !== 26'h1) begin
            failures++;
            $display("FAIL reset_midstream: got %h want %h", act, 26'h1);
        end
        release_reset();
        tick();
        checks++;
        if (pmod_ready_o !== 1'b1 || rx_level_o !== 4'd0) begin
            failures++;
            $display("FAIL reset_recover: ready=%b level=%0d want 1/0", pmod_ready_o, rx_level_o);
        end
    endtask

    task automatic test_single_word();
        pmod_valid_i = 1'b1; pmod_data_i = 8'hA5;
        tick();
        pmod_valid_i = 1'b0;
        checks++;
        if (core_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL single_early: core_valid got %b want 0 after capture edge", core_valid_o);
        end
        tick();
        checks++;
        if (core_valid_o !== 1'b1 || core_data_o !== 8'hA5 || rx_level_o !== 4'd1) begin
            failures++;
            $display("FAIL single_word: vld=%b data=%h lvl=%0d want 1/a5/1",
                     core_valid_o, core_data_o, rx_level_o);
        end
        core_ready_i = 1'b1;
        tick();
        core_ready_i = 1'b0;
        checks++;
        if (core_valid_o !== 1'b0 || rx_level_o !== 4'd0) begin
            failures++;
            $display("FAIL single_pop: vld=%b lvl=%0d want 0/0", core_valid_o, rx_level_o);
        end
    endtask

    // Host honours ready, sending one more word after it sees ready low.
    task automatic test_fill();
        int  extra = 0;
        bit  seen_low = 0;
        core_ready_i = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (!pmod_ready_o && !seen_low) begin
                seen_low = 1;
                checks++;
                if (rx_level_o !== 4'd6) begin
                    failures++;
                    $display("FAIL fill_ready_fall: level got %0d want 6", rx_level_o);
                end
            end
            if (pmod_ready_o) begin
                pmod_valid_i = 1'b1; pmod_data_i = DW'($urandom);
            end else if (extra < SKID - 1) begin
                pmod_valid_i = 1'b1; pmod_data_i = DW'($urandom);
                extra++;
            end else begin
                pmod_valid_i = 1'b0;
            end
            tick();
        end
        pmod_valid_i = 1'b0;
        tick();
        checks++;
        if (!seen_low || rx_level_o !== 4'd8 || overflow_o !== 1'b0 || pmod_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL fill_end: seen_low=%b lvl=%0d ovf=%b rdy=%b want 1/8/0/0",
                     seen_low, rx_level_o, overflow_o, pmod_ready_o);
        end
    endtask

    task automatic test_overflow();
        int popped = 0;
        pmod_valid_i = 1'b1; pmod_data_i = 8'h5A;
        tick();
        pmod_valid_i = 1'b0;
        tick();
        checks++;
        if (rx_level_o !== 4'd8 || overflow_o !== 1'b1) begin
            failures++;
            $display("FAIL overflow_set: lvl=%0d ovf=%b want 8/1", rx_level_o, overflow_o);
        end
        core_ready_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (core_valid_o !== (rxq.size() != 0) ||
                (rxq.size() != 0 && core_data_o !== rxq[0])) begin
                failures++;
                $display("FAIL overflow_drain[%0d]: vld=%b data=%h want vld=%b data=%h",
                         c, core_valid_o, core_data_o, rxq.size() != 0,
                         (rxq.size() != 0) ? rxq[0] : 8'h00);
            end
            if (core_valid_o) popped++;
            tick();
        end
        core_ready_i = 1'b0;
        checks++;
        if (popped != 8 || overflow_o !== 1'b1 || rx_level_o !== 4'd0) begin
            failures++;
            $display("FAIL overflow_after: popped=%0d ovf=%b lvl=%0d want 8/1/0",
                     popped, overflow_o, rx_level_o);
        end
    endtask

    task automatic test_full_pop();
        logic [DW-1:0] last = '0;
        apply_reset();
        release_reset();
        tick();
        test_fill();
        pmod_valid_i = 1'b1; pmod_data_i = 8'hC3;
        tick();
        pmod_valid_i = 1'b0; core_ready_i = 1'b1;
        tick();
        core_ready_i = 1'b0;
        checks++;
        if (rx_level_o !== 4'd8 || overflow_o !== 1'b0) begin
            failures++;
            $display("FAIL full_pop: lvl=%0d ovf=%b want 8/0", rx_level_o, overflow_o);
        end
        core_ready_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (core_valid_o !== (rxq.size() != 0) ||
                (rxq.size() != 0 && core_data_o !== rxq[0])) begin
                failures++;
                $display("FAIL full_pop_drain[%0d]: vld=%b data=%h", c, core_valid_o, core_data_o);
            end
            if (core_valid_o) last = core_data_o;
            tick();
        end
        core_ready_i = 1'b0;
        checks++;
        if (last !== 8'hC3) begin
            failures++;
            $display("FAIL full_pop_last: got %h want c3", last);
        end
    endtask

    task automatic test_tx_stall();
        pmod_hash_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            core_hash_valid_i = 1'b1; core_hash_i = 8'h10 + 8'(i);
            tick();
        end
        core_hash_i = 8'hEE;
        tick();
        core_hash_valid_i = 1'b0;
        checks++;
        if (core_hash_ready_o !== 1'b0 || pmod_hash_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL tx_stall: hrdy=%b hvld=%b want 0/0", core_hash_ready_o, pmod_hash_valid_o);
        end
        pmod_hash_ready_i = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            checks++;
            if (k >= 2 && k <= 5) begin
                if (pmod_hash_valid_o !== 1'b1 || pmod_hash_o !== 8'h10 + 8'(k - 2)) begin
                    failures++;
                    $display("FAIL tx_launch[%0d]: vld=%b data=%h want 1/%h",
                             k, pmod_hash_valid_o, pmod_hash_o, 8'h10 + 8'(k - 2));
                end
            end else if (pmod_hash_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL tx_idle[%0d]: vld=%b want 0", k, pmod_hash_valid_o);
            end
        end
        checks++;
        if (core_hash_ready_o !== 1'b1 || pmod_hash_o !== 8'h13) begin
            failures++;
            $display("FAIL tx_after: hrdy=%b data=%h want 1/13", core_hash_ready_o, pmod_hash_o);
        end
        pmod_hash_ready_i = 1'b0;
    endtask

    task automatic test_random();
        apply_reset();
        release_reset();
        tick();
        for (int c = 0; c < 600; c++) begin
            pmod_valid_i      = ($urandom_range(0, 9) < 6) && (c >= 300 || pmod_ready_o);
            pmod_data_i       = DW'($urandom);
            core_ready_i      = $urandom_range(0, 1) == 1;
            core_hash_valid_i = $urandom_range(0, 1) == 1;
            core_hash_i       = DW'($urandom);
            pmod_hash_ready_i = $urandom_range(0, 9) < 6;
            tick();
            checks++;
            if (core_valid_o !== (rxq.size() != 0) || rx_level_o !== LW'(rxq.size()) ||
                pmod_ready_o !== m_ready || overflow_o !== m_ovf) begin
                failures++;
                $display("FAIL rand_rx[%0d]: vld=%b lvl=%0d rdy=%b ovf=%b want %b/%0d/%b/%b", c,
                         core_valid_o, rx_level_o, pmod_ready_o, overflow_o,
                         rxq.size() != 0, rxq.size(), m_ready, m_ovf);
            end
            if (rxq.size() != 0) begin
                checks++;
                if (core_data_o !== rxq[0]) begin
                    failures++;
                    $display("FAIL rand_rx_data[%0d]: got %h want %h", c, core_data_o, rxq[0]);
                end
            end
            checks++;
            if (core_hash_ready_o !== (txq.size() < TXD) || pmod_hash_valid_o !== m_hvld ||
                pmod_hash_o !== m_hash) begin
                failures++;
                $display("FAIL rand_tx[%0d]: hrdy=%b hvld=%b hash=%h want %b/%b/%h", c,
                         core_hash_ready_o, pmod_hash_valid_o, pmod_hash_o,
                         txq.size() < TXD, m_hvld, m_hash);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single_word();
        test_fill();
        test_overflow();
        test_full_pop();
        test_tx_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
